// File: rtl/mimc_sponge_if.sv
// Stream-in / digest-out bus of mimc_feistel_sponge, including the round-constant ROM port.
// The slave modport is the hash block; master is the message source and digest consumer.
interface mimc_sponge_if #(
    parameter int N_BITS = 254,
    parameter int RC_W   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_data;
    logic              in_last;
    logic [N_BITS-1:0] key;
    logic [RC_W-1:0]   rc_idx;
    logic [N_BITS-1:0] rc;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_left;
    logic [N_BITS-1:0] out_right;
    logic              busy;

    modport master (
        output in_valid, in_data, in_last, key, rc, out_ready,
        input  in_ready, rc_idx, out_valid, out_left, out_right, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, key, rc, out_ready,
        output in_ready, rc_idx, out_valid, out_left, out_right, busy
    );
endinterface

// File: rtl/mimc_feistel_sponge.sv
// Iterative MiMC-Feistel (x^5) sponge hash over GF(P) with a shift-and-add modular multiplier.
// Define MIMC_SPONGE_PERF_CNT_EN to add the perf_cycles busy-cycle counter output.
module mimc_modmul #(
    parameter int                N_BITS = 254,
    parameter logic [N_BITS-1:0] P      = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter string             METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic              done,
    output logic [N_BITS-1:0] y
);
    localparam int CNT_W = $clog2(N_BITS + 1);

    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] x, input logic [N_BITS-1:0] z);
        logic [N_BITS:0] s;
        s = {1'b0, x} + {1'b0, z};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[N_BITS-1:0];
    endfunction

    if (METHOD == "peasant") begin : g_peasant
        logic [N_BITS-1:0] a_r, b_r, acc, acc_nxt;
        logic [CNT_W-1:0]  cnt;
        logic              run;

        // MSB-first double-and-add keeps acc reduced below P at every step.
        // NOTE: defaults come first in always_comb so no path leaves a signal unassigned (no latch).
        always_comb begin
            acc_nxt = mod_add(acc, acc);
            if (b_r[N_BITS-1]) acc_nxt = mod_add(acc_nxt, a_r);
        end

        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                run  <= 1'b0;
                done <= 1'b0;
                cnt  <= '0;
                a_r  <= '0;
                b_r  <= '0;
                acc  <= '0;
            end else begin
                done <= 1'b0;
                if (start && !run) begin
                    a_r <= a;
                    b_r <= b;
                    acc <= '0;
                    cnt <= CNT_W'(N_BITS);
                    run <= 1'b1;
                end else if (run) begin
                    acc <= acc_nxt;
                    b_r <= b_r << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        run  <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
        assign y = acc;
    end else begin : g_unsupported
        // Only shift-and-add is implemented; any other method never completes.
        assign done = 1'b0;
        assign y    = '0;
    end
endmodule

module mimc_feistel_sponge #(
    parameter int                N_BITS             = 254,
    parameter logic [N_BITS-1:0] P                  = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                N_ROUNDS           = 220,
    parameter string             GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst_n,
    mimc_sponge_if.slave      bus
`ifdef MIMC_SPONGE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);
    localparam int RC_W = $clog2(N_ROUNDS);
    localparam logic [RC_W-1:0] R_LAST = RC_W'(N_ROUNDS - 1);

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_ADD = 3'd2, S_SQ1 = 3'd3,
                           S_SQ2  = 3'd4, S_MUL  = 3'd5, S_FEIS = 3'd6, S_OUT = 3'd7;

    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] x, input logic [N_BITS-1:0] z);
        logic [N_BITS:0] s;
        s = {1'b0, x} + {1'b0, z};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[N_BITS-1:0];
    endfunction

    logic [2:0]        state;
    logic [N_BITS-1:0] l_r, r_r, key_r, t_r, p_r;
    logic [RC_W-1:0]   rnd;
    logic              last_r, in_ready_r, mul_start, mul_done, beat;
    logic [N_BITS-1:0] mul_a, mul_b, mul_y, din, kin, absorb_l;

    assign beat     = bus.in_valid && in_ready_r;
    assign din      = (bus.in_data >= P) ? bus.in_data - P : bus.in_data;
    assign kin      = (bus.key >= P) ? bus.key - P : bus.key;
    assign absorb_l = (state == S_WAIT) ? mod_add(l_r, din) : din;

    // p_r carries t^2, then t^4, then t^5 through the three multiplier passes.
    always_comb begin
        mul_a = p_r;
        mul_b = p_r;
        case (state)
            S_SQ1:   begin mul_a = t_r; mul_b = t_r; end
            S_MUL:   mul_b = t_r;
            default: ;
        endcase
    end

    mimc_modmul #(.N_BITS(N_BITS), .P(P), .METHOD(GALOIS_MULT_METHOD)) u_mul (
        .clk(clk), .rst_n(rst_n), .start(mul_start), .a(mul_a), .b(mul_b),
        .done(mul_done), .y(mul_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            l_r        <= '0;
            r_r        <= '0;
            key_r      <= '0;
            t_r        <= '0;
            p_r        <= '0;
            rnd        <= '0;
            last_r     <= 1'b0;
            in_ready_r <= 1'b0;
            mul_start  <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                S_IDLE, S_WAIT: begin
                    in_ready_r <= 1'b1;
                    if (beat) begin
                        if (state == S_IDLE) begin
                            key_r <= kin;
                            r_r   <= '0;
                        end
                        l_r        <= absorb_l;
                        last_r     <= bus.in_last;
                        rnd        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= S_ADD;
                    end
                end
                S_ADD: begin
                    t_r       <= mod_add(mod_add(l_r, key_r), bus.rc);
                    mul_start <= 1'b1;
                    state     <= S_SQ1;
                end
                S_SQ1, S_SQ2: if (mul_done) begin
                    p_r       <= mul_y;
                    mul_start <= 1'b1;
                    state     <= (state == S_SQ1) ? S_SQ2 : S_MUL;
                end
                S_MUL: if (mul_done) begin
                    p_r   <= mul_y;
                    state <= S_FEIS;
                end
                S_FEIS: begin
                    if (rnd != R_LAST) begin
                        l_r   <= mod_add(r_r, p_r);
                        r_r   <= l_r;
                        rnd   <= rnd + 1'b1;
                        state <= S_ADD;
                    end else begin
                        // Final round skips the swap.
                        r_r <= mod_add(r_r, p_r);
                        rnd <= '0;
                        if (last_r) begin
                            state <= S_OUT;
                        end else begin
                            state      <= S_WAIT;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                S_OUT: if (bus.out_ready) begin
                    l_r        <= '0;
                    r_r        <= '0;
                    in_ready_r <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.rc_idx    = rnd;
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_left  = (state == S_OUT) ? l_r : '0;
    assign bus.out_right = (state == S_OUT) ? r_r : '0;

`ifdef MIMC_SPONGE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (state == S_IDLE && beat) begin
            perf_cycles <= '0;
        end else if (state != S_IDLE && state != S_OUT && perf_cycles != 32'hffff_ffff) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mimc_feistel_sponge.sv
// Scoreboard bench for mimc_feistel_sponge in the small field P=11, N_BITS=4, N_ROUNDS=2.
// Expected digests are hand-computed; a negedge monitor pops and compares each transferred digest.
module tb_mimc_feistel_sponge;
    typedef struct packed {
        logic [3:0] l;
        logic [3:0] r;
    } digest_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   ov_cyc = 0;
    logic ov_prev = 1'b0;
    logic [3:0] rom [2];
    digest_t exp_q[$];

    mimc_sponge_if #(.N_BITS(4), .RC_W(1)) bus ();

`ifdef MIMC_SPONGE_PERF_CNT_EN
    logic [31:0] perf_cycles;
    mimc_feistel_sponge #(.N_BITS(4), .P(4'd11), .N_ROUNDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .perf_cycles(perf_cycles));
`else
    mimc_feistel_sponge #(.N_BITS(4), .P(4'd11), .N_ROUNDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.rc = rom[bus.rc_idx];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: compare whenever a digest is transferred.
    always @(negedge clk) begin
        digest_t e;
        if (bus.out_valid && !ov_prev) ov_cyc = cyc;
        ov_prev = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("digest_unexpected", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("digest_left", 32'(bus.out_left), 32'(e.l));
                check("digest_right", 32'(bus.out_right), 32'(e.r));
`ifdef MIMC_SPONGE_PERF_CNT_EN
                check("perf_cycles", perf_cycles, 32'(ov_cyc - acc_cyc));
`endif
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic last, input logic [3:0] k,
                        input logic push, input logic [3:0] el, input logic [3:0] er);
        int   n = 0;
        logic was_idle;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.key      = k;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", 32'(bus.in_ready), 32'd1);
        was_idle = !bus.busy;
        if (push) exp_q.push_back('{l: el, r: er});
        @(posedge clk); #1;
        if (was_idle) acc_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_absorb();
        int n = 0;
        while (!(bus.in_ready && bus.busy) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_busy", 32'(bus.busy), 32'd1);
        check("wait_no_out", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.key       = '0;
        bus.out_ready = 1'b1;
        rom[0] = 4'd0;
        rom[1] = 4'd0;
        #1;
        check("reset_outputs", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.rc_idx,
                                    bus.out_left, bus.out_right}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single element, key 0: (1,2); busy stays high until the digest is taken.
        send(4'd1, 1'b1, 4'd0, 1'b1, 4'd1, 4'd2);
        check("t1_busy", 32'(bus.busy), 32'd1);
        wait_idle();

        // Two elements: WAIT after the first, digest (3,4).
        send(4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        wait_absorb();
        send(4'd2, 1'b1, 4'd0, 1'b1, 4'd3, 4'd4);
        wait_idle();

        // Key 5, data 10: modular wrap in both the adds and x^5.
        send(4'd10, 1'b1, 4'd5, 1'b1, 4'd1, 4'd9);
        wait_idle();

        // Non-zero round constants {3,7} and in_data 15 reduced to 4: digest (10,3).
        rom[0] = 4'd3;
        rom[1] = 4'd7;
        send(4'd15, 1'b1, 4'd0, 1'b1, 4'd10, 4'd3);
        wait_idle();
        rom[0] = 4'd0;
        rom[1] = 4'd0;

        // Backpressure: digest held stable for 5 cycles with out_ready low.
        bus.out_ready = 1'b0;
        send(4'd1, 1'b1, 4'd0, 1'b1, 4'd1, 4'd2);
        for (int n = 0; n < 2000 && !bus.out_valid; n++) @(negedge clk);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data", 32'({bus.out_left, bus.out_right}), 32'h12);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_xfer", 32'(bus.in_ready), 32'd1);
        check("bp_idle_after_xfer", 32'(bus.busy), 32'd0);

        // Reset in the middle of the second element's squaring: abort, no digest.
        send(4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        wait_absorb();
        send(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.rc_idx,
                                    bus.out_left, bus.out_right}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(4'd1, 1'b1, 4'd0, 1'b1, 4'd1, 4'd2);
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
